// File: rtl/register_file_bank.sv
// register_file_bank: 31 writable WIDTH-bit general registers plus a
// hard-wired zero register (GR0), one write port and two registered read
// ports (PA/PB) with a read-valid flag (RV) one cycle after an accepted read.
//
// Optional feature, macro REGFILE_BYPASS_EN:
//   defined   -> a read of address X on the same edge as a write to X (X != 0)
//                returns the data being written (write-through forwarding).
//   undefined -> the same case returns the pre-write contents of X.

// 32-to-1 read multiplexer, one instance per read port.
module register_file_bank_mux32 #(
  parameter int WIDTH = 32
) (
  input  logic [31:0][WIDTH-1:0] din,
  input  logic [4:0]             sel,
  output logic [WIDTH-1:0]       dout
);

  assign dout = din[sel];

endmodule

module register_file_bank #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LE,
  input  logic [4:0]       RW,
  input  logic [WIDTH-1:0] PW,
  input  logic             RE,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  output logic [WIDTH-1:0] PA,
  output logic [WIDTH-1:0] PB,
  output logic             RV
);

  // GR0 has no storage; only registers 1..NREG-1 are real flops.
  logic [NREG-1:1][WIDTH-1:0] regs_q, regs_d;
  logic [WIDTH-1:0]           pa_q, pa_d;
  logic [WIDTH-1:0]           pb_q, pb_d;
  logic                       rv_q, rv_d;

  logic [31:0][WIDTH-1:0]     mux_in;
  logic [WIDTH-1:0]           mux_a, mux_b;
  logic [WIDTH-1:0]           rd_a, rd_b;

  // Mux input vector: slot 0 is the constant zero register.
  for (genvar gi = 0; gi < 32; gi++) begin : g_mux_in
    if (gi == 0) begin : g_zero
      assign mux_in[gi] = '0;
    end else begin : g_reg
      assign mux_in[gi] = regs_q[gi];
    end
  end

  register_file_bank_mux32 #(.WIDTH(WIDTH)) u_mux_a (
    .din  (mux_in),
    .sel  (RA),
    .dout (mux_a)
  );

  register_file_bank_mux32 #(.WIDTH(WIDTH)) u_mux_b (
    .din  (mux_in),
    .sel  (RB),
    .dout (mux_b)
  );

`ifdef REGFILE_BYPASS_EN
  // Forward write data to a read port addressing the register being written.
  always_comb begin
    rd_a = mux_a;
    rd_b = mux_b;
    if (LE && (RW != 5'd0) && (RW == RA)) rd_a = PW;
    if (LE && (RW != 5'd0) && (RW == RB)) rd_b = PW;
  end
`else
  // Reads see the register contents before this edge's write.
  always_comb begin
    rd_a = mux_a;
    rd_b = mux_b;
  end
`endif

  // Next register contents: only the addressed nonzero register changes.
  always_comb begin
    regs_d = regs_q;
    if (LE && (RW != 5'd0)) regs_d[RW] = PW;
  end

  // Read outputs load on an enabled read and hold otherwise; RV tracks RE.
  always_comb begin
    pa_d = pa_q;
    pb_d = pb_q;
    rv_d = RE;
    if (RE) begin
      pa_d = rd_a;
      pb_d = rd_b;
    end
  end

  // State update; reset overrides any write or read on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      regs_q <= '0;
      pa_q   <= '0;
      pb_q   <= '0;
      rv_q   <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pa_q   <= pa_d;
      pb_q   <= pb_d;
      rv_q   <= rv_d;
    end
  end

  assign PA = pa_q;
  assign PB = pb_q;
  assign RV = rv_q;

endmodule

// File: tb/tb_register_file_bank.sv
// Self-checking bench for register_file_bank: directed scenarios plus a
// randomized run, all checked against a behavioural register-file model.
module tb_register_file_bank;

  logic        CLK = 1'b0;
  logic        RST, LE, RE;
  logic [4:0]  RW, RA, RB;
  logic [31:0] PW;
  logic [31:0] PA, PB;
  logic        RV;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // Behavioural model: architectural register contents and expected outputs.
  logic [31:0] mem [32];
  logic [31:0] m_pa, m_pb;
  logic        m_rv;

  register_file_bank #(.WIDTH(32), .NREG(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .LE  (LE),
    .RW  (RW),
    .PW  (PW),
    .RE  (RE),
    .RA  (RA),
    .RB  (RB),
    .PA  (PA),
    .PB  (PB),
    .RV  (RV)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] model_read(input logic le, input logic [4:0] rw,
                                             input logic [31:0] pw, input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (BYP && le && (rw == ra)) return pw;
    return mem[ra];
  endfunction

  // Apply one edge's inputs, advance one clock, update the model.
  task automatic tick(input logic rst, input logic le, input logic [4:0] rw,
                      input logic [31:0] pw, input logic re,
                      input logic [4:0] ra, input logic [4:0] rb);
    RST = rst; LE = le; RW = rw; PW = pw; RE = re; RA = ra; RB = rb;
    @(posedge CLK);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      m_pa = 32'd0;
      m_pb = 32'd0;
      m_rv = 1'b0;
    end else begin
      m_rv = re;
      if (re) begin
        m_pa = model_read(le, rw, pw, ra);
        m_pb = model_read(le, rw, pw, rb);
      end
      if (le && rw != 5'd0) mem[rw] = pw;
    end
    $display("[TB] t=%0t rst=%0b le=%0b rw=%0d pw=%h re=%0b ra=%0d rb=%0d -> PA=%h PB=%h RV=%0b",
             $time, rst, le, rw, pw, re, ra, rb, PA, PB, RV);
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0, 0, 0);
    tests++;
    if (PA !== 32'd0 || PB !== 32'd0 || RV !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: PA=%h PB=%h RV=%b, required 0 0 0", PA, PB, RV);
    end
    // Idle edge after deassertion changes nothing.
    tick(0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (PA !== 32'd0 || PB !== 32'd0 || RV !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: PA=%h PB=%h RV=%b, required 0 0 0", PA, PB, RV);
    end
    tick(0, 0, 0, 0, 1, 5, 31);
    tests++;
    if (PA !== 32'd0 || PB !== 32'd0 || RV !== 1'b1) begin
      fails++;
      $display("FAIL reset_read: PA=%h PB=%h RV=%b, required 0 0 1", PA, PB, RV);
    end
  endtask

  task automatic test_fill_read();
    for (int i = 1; i < 32; i++) tick(0, 1, 5'(i), 32'(i * 10), 0, 0, 0);
    tests++;
    if (RV !== 1'b0) begin
      fails++;
      $display("FAIL fill_rv_idle: RV=%b, required 0", RV);
    end
    tick(0, 0, 0, 0, 1, 8, 16);
    tests++;
    if (PA !== 32'd80 || PB !== 32'd160 || RV !== 1'b1) begin
      fails++;
      $display("FAIL fill_read: PA=%0d PB=%0d RV=%b, required 80 160 1", PA, PB, RV);
    end
    tick(0, 0, 0, 0, 1, 31, 31);
    tests++;
    if (PA !== 32'd310 || PB !== 32'd310) begin
      fails++;
      $display("FAIL same_addr_read: PA=%0d PB=%0d, required 310 310", PA, PB);
    end
  endtask

  task automatic test_gr0();
    tick(0, 1, 0, 32'hDEADBEEF, 1, 0, 0);
    tests++;
    if (PA !== 32'd0 || PB !== 32'd0) begin
      fails++;
      $display("FAIL gr0_same_edge: PA=%h PB=%h, required 0 0", PA, PB);
    end
    tick(0, 0, 0, 0, 1, 0, 1);
    tests++;
    if (PA !== 32'd0 || PB !== 32'd10) begin
      fails++;
      $display("FAIL gr0_read: PA=%h PB=%0d, required 0 10", PA, PB);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] exp_pa;
    exp_pa = BYP ? 32'd99 : 32'd40;
    tick(0, 1, 4, 32'd99, 1, 4, 5);
    tests++;
    if (PA !== exp_pa || PB !== 32'd50) begin
      fails++;
      $display("FAIL same_edge_rw: PA=%0d PB=%0d, required %0d 50", PA, PB, exp_pa);
    end
    tick(0, 0, 0, 0, 1, 4, 4);
    tests++;
    if (PA !== 32'd99 || PB !== 32'd99) begin
      fails++;
      $display("FAIL same_edge_after: PA=%0d PB=%0d, required 99 99", PA, PB);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    tick(0, 1, 7, a, 0, 0, 0);
    tick(0, 1, 7, b, 0, 0, 0);
    tick(0, 1, 7, c, 1, 7, 6);
    tests++;
    if (PA !== m_pa || PB !== 32'd60) begin
      fails++;
      $display("FAIL back_to_back_mid: PA=%h PB=%0d, required %h 60", PA, PB, m_pa);
    end
    tick(0, 0, 0, 0, 1, 7, 0);
    tests++;
    if (PA !== c) begin
      fails++;
      $display("FAIL back_to_back_last: PA=%h, required %h", PA, c);
    end
  endtask

  task automatic test_reset_dominates();
    tick(0, 0, 0, 0, 1, 3, 3);
    tick(1, 1, 3, 32'd7, 1, 3, 3);
    tests++;
    if (PA !== 32'd0 || PB !== 32'd0 || RV !== 1'b0) begin
      fails++;
      $display("FAIL rst_dominates: PA=%h PB=%h RV=%b, required 0 0 0", PA, PB, RV);
    end
    tick(0, 0, 0, 0, 1, 3, 8);
    tests++;
    if (PA !== 32'd0 || PB !== 32'd0 || RV !== 1'b1) begin
      fails++;
      $display("FAIL rst_cleared_read: PA=%h PB=%h RV=%b, required 0 0 1", PA, PB, RV);
    end
  endtask

  task automatic test_hold();
    tick(0, 1, 31, 32'd1234, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 31, 0);
    tests++;
    if (PA !== 32'd1234 || RV !== 1'b1) begin
      fails++;
      $display("FAIL hold_setup: PA=%0d RV=%b, required 1234 1", PA, RV);
    end
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 31, $urandom, 0, 5'($urandom), 5'($urandom));
      tests++;
      if (PA !== 32'd1234 || RV !== 1'b0) begin
        fails++;
        $display("FAIL hold_cycle%0d: PA=%0d RV=%b, required 1234 0", k, PA, RV);
      end
    end
    tick(0, 0, 0, 0, 1, 31, 31);
    tests++;
    if (PA !== mem[31] || PB !== mem[31]) begin
      fails++;
      $display("FAIL hold_release: PA=%h PB=%h, required %h", PA, PB, mem[31]);
    end
  endtask

  task automatic test_rst_abort();
    tick(0, 0, 0, 0, 1, 1, 2);
    tick(1, 0, 0, 0, 1, 1, 2);
    tests++;
    if (RV !== 1'b0 || PA !== 32'd0) begin
      fails++;
      $display("FAIL rst_abort: RV=%b PA=%h, required 0 0", RV, PA);
    end
  endtask

  task automatic test_random();
    logic        rst, le, re;
    logic [4:0]  rw, ra, rb;
    logic [31:0] pw;
    for (int n = 0; n < 250; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      le  = $urandom_range(0, 1);
      re  = $urandom_range(0, 1);
      rw  = 5'($urandom);
      pw  = $urandom;
      ra  = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
      tick(rst, le, rw, pw, re, ra, rb);
      tests++;
      if (PA !== m_pa || PB !== m_pb || RV !== m_rv) begin
        fails++;
        $display("FAIL random_%0d: PA=%h PB=%h RV=%b, required %h %h %b",
                 n, PA, PB, RV, m_pa, m_pb, m_rv);
      end
    end
  endtask

  initial begin
    RST = 1'b1; LE = 1'b0; RE = 1'b0; RW = '0; RA = '0; RB = '0; PW = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    m_pa = 32'd0; m_pb = 32'd0; m_rv = 1'b0;
    @(negedge CLK);
    test_reset();
    test_fill_read();
    test_gr0();
    test_same_edge();
    test_back_to_back();
    test_hold();
    test_reset_dominates();
    test_rst_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
